// File: rtl/change_dispenser.sv
// Vend sequencer: pays out the latched change one coin at a time over a req/ack
// hopper handshake, then runs the brew valve, reporting completion and hopper faults.
module change_dispenser #(
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int BREW_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_t,
    input  logic       cmd_w,
    input  logic       cmd_f,
    input  logic       cmd_m,
    input  logic       cmd_o,
    output logic [2:0] coin_sel,
    input  logic       coin_ack,
    output logic       brew,
    output logic       busy,
    output logic       done,
    output logic [7:0] paid_out,
    output logic       fault
);

    localparam int CNT_MAX =
        (ACK_TIMEOUT > GAP_CYCLES)
            ? ((ACK_TIMEOUT > BREW_CYCLES) ? ACK_TIMEOUT : BREW_CYCLES)
            : ((GAP_CYCLES > BREW_CYCLES) ? GAP_CYCLES : BREW_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, NEXT, COIN_REQ, COIN_GAP, BREW, DONE, FAULT
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             n50_reg;
    logic [1:0]       n20_reg;
    logic             n10_reg;
    logic             coffee_reg;
    logic             cmd_ready_reg;
    logic [2:0]       coin_sel_reg;
    logic             brew_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [7:0]       paid_out_reg;
    logic             fault_reg;
    logic [7:0]       coin_value;

    // Value of the coin currently being requested; coin_sel_reg is one-hot.
    always_comb begin
        coin_value = 8'd0;
        if (coin_sel_reg[2])
            coin_value = 8'd50;
        else if (coin_sel_reg[1])
            coin_value = 8'd20;
        else if (coin_sel_reg[0])
            coin_value = 8'd10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            n50_reg       <= 1'b0;
            n20_reg       <= 2'd0;
            n10_reg       <= 1'b0;
            coffee_reg    <= 1'b0;
            cmd_ready_reg <= 1'b1;
            coin_sel_reg  <= 3'b000;
            brew_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            paid_out_reg  <= 8'd0;
            fault_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        n50_reg       <= cmd_f;
                        n20_reg       <= cmd_w ? (cmd_m ? 2'd2 : 2'd1) : 2'd0;
                        n10_reg       <= cmd_t;
                        coffee_reg    <= cmd_o;
                        paid_out_reg  <= 8'd0;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= NEXT;
                    end
                end
                NEXT: begin
                    cnt_reg <= '0;
                    if (n50_reg) begin
                        coin_sel_reg <= 3'b100;
                        state_reg    <= COIN_REQ;
                    end else if (n20_reg != 2'd0) begin
                        coin_sel_reg <= 3'b010;
                        state_reg    <= COIN_REQ;
                    end else if (n10_reg) begin
                        coin_sel_reg <= 3'b001;
                        state_reg    <= COIN_REQ;
                    end else if (coffee_reg) begin
                        brew_reg  <= 1'b1;
                        state_reg <= BREW;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                COIN_REQ: begin
                    // An ack in the final waiting cycle still wins over the timeout.
                    if (coin_ack) begin
                        if (coin_sel_reg[2])
                            n50_reg <= 1'b0;
                        if (coin_sel_reg[1])
                            n20_reg <= n20_reg - 2'd1;
                        if (coin_sel_reg[0])
                            n10_reg <= 1'b0;
                        paid_out_reg <= paid_out_reg + coin_value;
                        coin_sel_reg <= 3'b000;
                        cnt_reg      <= '0;
                        state_reg    <= COIN_GAP;
                    end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
                        coin_sel_reg <= 3'b000;
                        busy_reg     <= 1'b0;
                        fault_reg    <= 1'b1;
                        state_reg    <= FAULT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                COIN_GAP: begin
                    if (cnt_reg == CNT_W'(GAP_CYCLES - 1))
                        state_reg <= NEXT;
                    else
                        cnt_reg <= cnt_reg + CNT_W'(1);
                end
                BREW: begin
                    if (cnt_reg == CNT_W'(BREW_CYCLES - 1)) begin
                        brew_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                FAULT: begin
                    state_reg <= FAULT;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign coin_sel  = coin_sel_reg;
    assign brew      = brew_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign paid_out  = paid_out_reg;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes the expected coin order,
// payout and brew length; a monitor pops and compares on every done pulse.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_t = 1'b0, cmd_w = 1'b0, cmd_f = 1'b0, cmd_m = 1'b0, cmd_o = 1'b0;
    logic       coin_ack = 1'b0;
    logic       cmd_ready;
    logic [2:0] coin_sel;
    logic       brew, busy, done, fault;
    logic [7:0] paid_out;

    change_dispenser dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_t    (cmd_t),
        .cmd_w    (cmd_w),
        .cmd_f    (cmd_f),
        .cmd_m    (cmd_m),
        .cmd_o    (cmd_o),
        .coin_sel (coin_sel),
        .coin_ack (coin_ack),
        .brew     (brew),
        .busy     (busy),
        .done     (done),
        .paid_out (paid_out),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int seq;    // coin order, base-4 digits: 3=50, 2=20, 1=10
        int paid;
        int brewc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   ack_en = 1'b1;
    bit   stray_en = 1'b0;
    int   ack_delay = 1;
    int   txn_no = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: the coin list a vend command must produce, from the pricing rules.
    function automatic exp_t model(input bit f, input bit w, input bit m, input bit t, input bit o);
        exp_t e;
        int   n20;
        n20 = w ? (m ? 2 : 1) : 0;
        e.seq = 0;
        if (f) e.seq = e.seq * 4 + 3;
        for (int i = 0; i < n20; i++) e.seq = e.seq * 4 + 2;
        if (t) e.seq = e.seq * 4 + 1;
        e.paid  = 50 * int'(f) + 20 * n20 + 10 * int'(t);
        e.brewc = o ? 16 : 0;
        return e;
    endfunction

    task automatic check_reset_state(input string name);
        check(name, int'({cmd_ready, coin_sel, brew, busy, done, paid_out, fault}),
              int'({1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}));
    endtask

    // Hopper model: acks each request after ack_delay cycles, optional stray acks.
    initial begin
        forever begin
            @(negedge clk);
            if (coin_sel != 3'b000 && ack_en) begin
                repeat (ack_delay) @(negedge clk);
                coin_ack = 1'b1;
                @(negedge clk);
                coin_ack = 1'b0;
            end else if (coin_sel == 3'b000 && stray_en && $urandom_range(0, 3) == 0) begin
                coin_ack = 1'b1;
                @(negedge clk);
                coin_ack = 1'b0;
            end
        end
    end

    // Monitor: records coin requests and brew length, compares on each done.
    initial begin
        int   seq_obs;
        int   brew_obs;
        int   code;
        logic [2:0] prev_sel;
        exp_t e;
        seq_obs = 0; brew_obs = 0; prev_sel = 3'b000;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                seq_obs = 0; brew_obs = 0; prev_sel = 3'b000;
            end else begin
                if (coin_sel != 3'b000 && prev_sel == 3'b000) begin
                    code = (coin_sel == 3'b100) ? 3 : (coin_sel == 3'b010) ? 2 :
                           (coin_sel == 3'b001) ? 1 : 7;
                    seq_obs = seq_obs * 4 + code;
                end
                prev_sel = coin_sel;
                if (brew) brew_obs++;
                if (done) begin
                    txn_no++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("[TB] txn %0d coins=%0h/%0h paid=%0d/%0d brew=%0d/%0d",
                                 txn_no, seq_obs, e.seq, paid_out, e.paid, brew_obs, e.brewc);
                        check("coin_order", seq_obs, e.seq);
                        check("paid_out", int'(paid_out), e.paid);
                        check("brew_cycles", brew_obs, e.brewc);
                    end
                    seq_obs = 0; brew_obs = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", int'(cmd_ready), 1);
    endtask

    // Issues one command, pushes its expectation, waits for done; returns latency.
    task automatic run_txn(input bit f, input bit w, input bit m, input bit t, input bit o,
                           input bit hold, output int lat);
        int k = 0;
        wait_ready();
        cmd_f = f; cmd_w = w; cmd_m = m; cmd_t = t; cmd_o = o;
        cmd_valid = 1'b1;
        exp_q.push_back(model(f, w, m, t, o));
        do begin
            @(negedge clk);
            k++;
            if (!hold) begin
                cmd_valid = 1'b0;
            end else begin
                {cmd_f, cmd_w, cmd_m, cmd_t, cmd_o} = 5'($urandom);
            end
        end while (!done && k < 3000);
        cmd_valid = 1'b0;
        check("done_wait", int'(done), 1);
        lat = k;
    endtask

    initial begin
        int lat;
        int k;
        int bad;

        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        ack_delay = 1;
        run_txn(1, 1, 1, 1, 1, 0, lat);
        run_txn(0, 0, 1, 1, 0, 0, lat);
        run_txn(0, 0, 0, 0, 0, 0, lat);
        check("zero_cmd_latency", lat, 2);

        // Reset in the middle of brewing drops the transaction.
        mon_en = 1'b0;
        @(negedge clk);
        wait_ready();
        cmd_o = 1'b1; cmd_f = 1'b0; cmd_w = 1'b0; cmd_t = 1'b0; cmd_m = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!brew && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("brew_started", int'(brew), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midbrew_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("after_reset");
        exp_q.delete();
        mon_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            bit [4:0] fields;
            fields    = 5'($urandom);
            ack_delay = $urandom_range(0, 4);
            stray_en  = $urandom_range(0, 1);
            run_txn(fields[4], fields[3], fields[2], fields[1], fields[0],
                    ($urandom_range(0, 2) == 0), lat);
        end
        stray_en  = 1'b0;
        ack_delay = 1;

        // Hopper never acks: request times out into a sticky fault.
        mon_en = 1'b0;
        ack_en = 1'b0;
        @(negedge clk);
        wait_ready();
        cmd_f = 1'b1; cmd_w = 1'b0; cmd_t = 1'b0; cmd_m = 1'b0; cmd_o = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (coin_sel == 3'b000 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("fault_coin_sel_50", int'(coin_sel), 4);
        k = 0;
        while (!fault && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("fault_latency", k, 255);
        check("fault_outputs", int'({cmd_ready, coin_sel, brew, busy, fault}),
              int'({1'b0, 3'b000, 1'b0, 1'b0, 1'b1}));
        ack_en = 1'b1;
        cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (coin_sel != 3'b000 || !fault || done || cmd_ready) bad++;
        end
        cmd_valid = 1'b0;
        cmd_f = 1'b0;
        check("fault_sticky", bad, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("fault_cleared");
        mon_en = 1'b1;
        @(negedge clk);
        run_txn(1, 0, 0, 1, 0, 0, lat);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
